// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: byte-wide bus between the addition sequencer and the
// external combinational 8-bit adder it time-shares.
// The master side (sequencer) presents operand bytes and carry-in; the slave
// side (adder) returns the byte sum and carry-out in the same cycle.
interface add_seq_ctrl_if;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_out;
    logic       add_cout;

    modport master (
        output add_a,
        output add_b,
        output add_cin,
        input  add_out,
        input  add_cout
    );

    modport slave (
        input  add_a,
        input  add_b,
        input  add_cin,
        output add_out,
        output add_cout
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-byte addition sequencer. Adds two NBYTES-byte operands
// least-significant byte first through one external 8-bit adder, chaining the
// carry from cycle to cycle and assembling the result byte by byte.
// Optional feature: define ADDSEQ_OVF_EN to add the signed-overflow output ovf.
module add_seq_ctrl #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         sum,
    output logic                 cout,
`ifdef ADDSEQ_OVF_EN
    output logic                 ovf,
`endif
    add_seq_ctrl_if.master       adder
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [NBYTES-1:0][7:0]   a_q, a_d;
    logic [NBYTES-1:0][7:0]   b_q, b_d;
    logic [NBYTES-1:0][7:0]   sum_q, sum_d;
    logic                     carry_q, carry_d;
    logic                     cout_q, cout_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic                     accept;
    logic [7:0]               add_a_c;
    logic [7:0]               add_b_c;
    logic                     add_cin_c;

    // Next-state, datapath updates and adder-bus drive; the adder only sees
    // operand bytes while RUN, and a start in IDLE or DONE reloads everything.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        accept    = 1'b0;
        add_a_c   = 8'h00;
        add_b_c   = 8'h00;
        add_cin_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            RUN: begin
                add_a_c      = a_q[idx_q];
                add_b_c      = b_q[idx_q];
                add_cin_c    = carry_q;
                sum_d[idx_q] = adder.add_out;
                carry_d      = adder.add_cout;
                idx_d        = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = adder.add_cout;
                    ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                              (adder.add_out[7] != a_q[NBYTES-1][7]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = RUN;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset; reset during RUN
    // simply drops the operation, so no done is produced for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sum           = sum_q;
    assign cout          = cout_q;
    assign adder.add_a   = add_a_c;
    assign adder.add_b   = add_b_c;
    assign adder.add_cin = add_cin_c;

`ifdef ADDSEQ_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
